// File: rtl/cf_math_pkg.sv
// rtl/cf_math_pkg.sv - shared math helpers for address-map blocks
package cf_math_pkg;

    // Width of an index able to address num_idx items; never narrower than 1 bit
    // so that single-entry and empty sets still yield a legal vector width.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/addr_encode.sv
// rtl/addr_encode.sv - sequential index+offset to absolute address encoder
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   addr_map_i           address map (NoRules x rule_t), stable while busy_o=1
//   req_valid_i/ready_o  request handshake
//   req_idx_i            target index
//   req_offset_i         byte offset within the target region
//   rsp_valid_o/ready_i  response handshake
//   rsp_addr_o           start_addr + offset of matching rule, 0 on error
//   rsp_rule_o           number of the matching rule, 0 on error
//   rsp_error_o          no rule matched
//   busy_o               FSM not idle
module addr_encode #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned NoIndices = 2,
    parameter int unsigned NoRules   = 1,
    parameter int unsigned IdxWidth  = cf_math_pkg::idx_width(NoIndices),
    parameter int unsigned CntWidth  = cf_math_pkg::idx_width(NoRules),
    parameter type         rule_t    = logic [IdxWidth+2*AddrWidth-1:0]
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  rule_t [(NoRules > 0 ? NoRules : 1)-1:0] addr_map_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [IdxWidth-1:0]                   req_idx_i,
    input  logic [AddrWidth-1:0]                  req_offset_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [AddrWidth-1:0]                  rsp_addr_o,
    output logic [CntWidth-1:0]                   rsp_rule_o,
    output logic                                  rsp_error_o,
    output logic                                  busy_o
);

    localparam int unsigned RuleWidth = IdxWidth + 2 * AddrWidth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [AddrWidth-1:0]  offset_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [CntWidth-1:0]   rule_q;
    logic                  error_q;

    // The rule is handled as raw bits so any user struct with the
    // {idx, start_addr, end_addr} MSB-first layout works as rule_t.
    logic [RuleWidth-1:0]  rule_bits;
    logic [IdxWidth-1:0]   rule_idx;
    logic [AddrWidth-1:0]  rule_start;
    logic [AddrWidth-1:0]  rule_end;
    logic                  rule_nonempty;
    logic                  rule_hit;
    logic                  last_rule;

    assign rule_bits  = addr_map_i[cnt_q];
    assign rule_idx   = rule_bits[RuleWidth-1 -: IdxWidth];
    assign rule_start = rule_bits[2*AddrWidth-1 -: AddrWidth];
    assign rule_end   = rule_bits[AddrWidth-1:0];

    // Size comparison is gated by nonempty so a wrapped end-start never hits.
    assign rule_nonempty = rule_end > rule_start;
    assign rule_hit      = (rule_idx == idx_q) && rule_nonempty
                           && (offset_q < (rule_end - rule_start));
    assign last_rule     = (cnt_q == CntWidth'(NoRules - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            rule_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        idx_q    <= req_idx_i;
                        offset_q <= req_offset_i;
                        cnt_q    <= '0;
                        if (NoRules == 0) begin
                            addr_q  <= '0;
                            rule_q  <= '0;
                            error_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (rule_hit) begin
                        // Offset is below region size, so the sum cannot wrap.
                        addr_q  <= rule_start + offset_q;
                        rule_q  <= cnt_q;
                        error_q <= 1'b0;
                        state_q <= RESP;
                    end else if (last_rule) begin
                        addr_q  <= '0;
                        rule_q  <= '0;
                        error_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_addr_o  = addr_q;
    assign rsp_rule_o  = rule_q;
    assign rsp_error_o = error_q;

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=>
            (rsp_valid_o && $stable(rsp_addr_o) && $stable(rsp_rule_o) && $stable(rsp_error_o)));

    a_err_addr_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_error_o |-> (rsp_addr_o == '0));

endmodule

// File: doc/addr_encode.md
Name: addr_encode

Overview:
- Inverse of the address decoder: given a target index and a byte offset, finds the rule in the address map that belongs to that index and covers the offset, and returns the absolute address `start_addr + offset`.
- Sits beside the crossbar/decoder. Used by DMA and debug initiators that address a slave by port index rather than by absolute address.
- Performs a sequential scan, one rule per cycle, so large maps need no wide comparator tree.
- Uses valid/ready handshakes on both request and response.

Parameters:
- AddrWidth, 32: width of addresses and offsets.
- NoIndices, 2: number of target indices. IdxWidth = cf_math_pkg::idx_width(NoIndices).
- NoRules, 1: number of address-map rules. CntWidth = cf_math_pkg::idx_width(NoRules).
- rule_t, packed {idx[IdxWidth], start_addr[AddrWidth], end_addr[AddrWidth]}, MSB first: rule type, identical to the decoder's.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- addr_map_i  in  NoRules x rule_t  address map; must be stable while busy_o=1
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_idx_i  in  IdxWidth  target index
- req_offset_i  in  AddrWidth  byte offset within the region
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_addr_o  out  AddrWidth  resolved address; 0 on error
- rsp_rule_o  out  CntWidth  number of the matching rule; 0 on error
- rsp_error_o  out  1  no rule matched
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values (async, rst_ni=0):
  - state = IDLE.
  - req_ready_o=1, rsp_valid_o=0, rsp_addr_o=0, rsp_rule_o=0, rsp_error_o=0, busy_o=0.
  - Scan counter = 0; captured idx/offset = 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture idx and offset, clear the counter, go to SCAN.
  - If NoRules==0, go directly to RESP with error=1.
- SCAN (req_ready_o=0): evaluate rule[cnt] in the current cycle.
  - Hit condition: `rule.idx == idx_q`, AND `end_addr > start_addr`, AND `offset_q < (end_addr - start_addr)`. The subtraction is unsigned AddrWidth and is only evaluated when `end_addr > start_addr`.
  - On hit, register `addr = start_addr + offset_q` (AddrWidth, cannot overflow because the offset is below the region size), rule=cnt, error=0; go to RESP.
  - On miss with cnt == NoRules-1, register addr=0, rule=0, error=1; go to RESP.
  - Otherwise cnt++.
- First match wins: the lowest-numbered rule. Several rules may share an idx; each is checked with its own size.
- Rules with `end_addr <= start_addr` are empty and never hit.
- RESP:
  - rsp_valid_o=1, with rsp_addr_o, rsp_rule_o and rsp_error_o held stable until `rsp_valid_o && rsp_ready_i`, then return to IDLE.
  - req_ready_o=0 in RESP. There is no overlap of a new request with a pending response.
- Latency: request accepted at edge T, hit on rule i → rsp_valid_o high in cycle T+2+i.
  - Full miss → rsp_valid_o high in cycle T+1+NoRules.
  - NoRules==0 → rsp_valid_o high in cycle T+1.
- Backpressure: response outputs must not change while rsp_valid_o=1 and rsp_ready_i=0.
- Reset mid-scan or mid-response: return immediately to the reset state. The pending request is dropped with no response.
- rsp_addr_o, rsp_rule_o and rsp_error_o are registered outputs. req_ready_o and busy_o decode directly from state.
- Assertions:
  - Response outputs stable under backpressure.
  - rsp_error_o implies rsp_addr_o==0.

Decomposition:
- Package: none new. Reuse cf_math_pkg::idx_width.
- rule_t stays a type parameter so the decoder and encoder share the same user-defined rule struct.
- No sub-module; the response register is in-line.

Test Plan:
All scenarios use AddrWidth=32, NoIndices=4, NoRules=3, with rule0={1,0x1000,0x2000}, rule1={2,0x2000,0x3000}, rule2={1,0x8000,0x8100}.
- idx=2, off=0x10 → addr=0x2010, rule=1, err=0, rsp_valid at T+3.
- idx=1, off=0x80 → addr=0x1080, rule=0, rsp_valid at T+2. idx=1, off=0x1000 → rule0 miss (offset equals size), rule2 miss → err=1, addr=0, rsp_valid at T+4.
- idx=1, off=0x20 with rule0 set to {1,0x1000,0x1000} (empty) → rule0 skipped, addr=0x8020, rule=2. idx=3, off=0 → err=1.
- Backpressure: rsp_ready_i=0 for 5 cycles on the idx=2 request → addr/rule/err stable, req_ready_o=0, no second request accepted. Ready then high → IDLE next cycle.
- Reset: rst_ni low in cycle T+2 during the scan → all outputs at reset values immediately, no response. After release, a new request resolves normally.
- Back-to-back: 100 random idx/offset requests with random rsp_ready_i → every result matches the reference model, and the response count equals the request count.
